rr_switch_allocator: RTL
========================

Name: rr_switch_allocator

Overview:
Round-robin switch allocator for one mesh router with INPUTS input ports and OUTPUTS output ports. Each input presents a head-flit request for one output. Each output runs its own allocation FSM: it grants one contending input in fair rotation and locks to that input until the tail-flit release. The block drives crossbar select and busy/lock status to the switch datapath and input buffers.

Parameters:
INPUTS, 4, number of router input ports
OUTPUTS, 4, number of router output ports
REQUEST_WIDTH, 2, width of one destination index and of one select field; must satisfy 2^REQUEST_WIDTH >= max(INPUTS, OUTPUTS)

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  INPUTS  bit i: input i requests the output in req_dest[i]
req_dest  input  INPUTS*REQUEST_WIDTH  field i: destination output index for input i
release  input  INPUTS  bit i: one-cycle pulse, input i has sent its tail flit
grant_ack  output  INPUTS  bit i: one-cycle registered pulse, input i was granted
input_locked  output  INPUTS  bit i: input i currently owns an output
route_select  output  OUTPUTS*REQUEST_WIDTH  field o: index of the input driving output o
output_busy  output  OUTPUTS  bit o: output o is locked to an owner

Behaviour:
- Reset (rst=1 at an edge) clears all state and all outputs: every output IDLE, every owner and route_select field 0, every rr pointer 0, grant_ack=0, input_locked=0, output_busy=0. Reset mid-transfer drops every lock unconditionally. No grant is issued in the reset cycle.
- Per-output FSM, two states:
  - IDLE -> LOCKED when the candidate set is non-empty.
  - LOCKED -> IDLE when release[owner]=1.
- Candidate set for output o in a cycle: inputs i with req_valid[i]=1, req_dest[i]==o, and input_locked[i]=0. If req_dest >= OUTPUTS, the request is ignored and never granted.
- Arbitration: pick the first candidate scanning i = ptr[o], ptr[o]+1, ..., wrapping modulo INPUTS. On grant, ptr[o] <= (winner+1) mod INPUTS. The pointer is unchanged when no grant occurs.
- Latency: request sampled at edge t. Next cycle (t+1) shows grant_ack[winner]=1 for exactly one cycle, output_busy[o]=1, input_locked[winner]=1, and route_select[o]=winner.
- Requester holds req_valid and a stable req_dest until it sees grant_ack. req_valid from a locked input is ignored.
- No two outputs can grant the same input. Each input has a single req_dest and is excluded once locked, so this holds by construction.
- Outputs arbitrate independently. Distinct outputs may grant in the same cycle.
- Release:
  - release[i] is acted on only if input i is the owner of a LOCKED output. Otherwise it is ignored.
  - Release sampled at edge t clears output_busy, input_locked and route_select (to 0) at t+1.
  - The output may be re-granted at the earliest one edge later, so the minimum idle gap is 1 cycle. Release and grant never happen on the same output in the same cycle.
  - A released input may request again in the cycle after its lock clears.
- route_select[o] holds the owner's index for the full LOCKED period and is 0 while IDLE. Datapath consumers must qualify it with output_busy.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, then req_valid=0001, req_dest[0]=2 at edge 1. Required: grant_ack=0001 on cycle 2 only; output_busy=0100; route_select[2]=0; input_locked=0001. Then release=0001 at edge 5: output_busy=0000 and input_locked=0000 at cycle 6.
- Inputs 0, 1 and 3 all request output 1 and hold. Each owner is released 3 cycles after its grant. Required: grant order 0, 1, 3, 0. Each grant comes 2 cycles after the prior release pulse. ptr[1] reaches 2 after granting input 1.
- In one cycle, inputs 0→3, 1→2, 2→1, 3→0. Required: all four grant_ack bits high in the same cycle; output_busy=1111; route_select fields {o3:0, o2:1, o1:2, o0:3}.
- While output 2 is owned by input 0, pulse release[1], and also drive req_valid[0]=1 with dest 3. Required: no state change; output 3 stays IDLE; output 2 stays locked to input 0.
- While input 2 owns output 0 and input 1 is waiting, assert rst for 1 cycle. Required: all outputs zero the next cycle with no grant_ack. Input 1 (still requesting) is granted 1 cycle after rst deasserts, because ptr was reset to 0.
- With INPUTS=4 and OUTPUTS=3, input 0 requests dest=3. Required: it is never granted, and all other outputs and requests are unaffected.

Source files
------------

// File: rtl/rr_switch_allocator_if.sv
// Request/grant bundle between the input ports and the switch allocator.
// slave = allocator side, master = input-port/datapath side.
interface rr_switch_allocator_if #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2
);
  logic [INPUTS-1:0]                i_req_valid;
  logic [INPUTS*REQUEST_WIDTH-1:0]  i_req_dest;
  logic [INPUTS-1:0]                i_release;
  logic [INPUTS-1:0]                o_grant_ack;
  logic [INPUTS-1:0]                o_input_locked;
  logic [OUTPUTS*REQUEST_WIDTH-1:0] o_route_select;
  logic [OUTPUTS-1:0]               o_output_busy;

  modport slave (
    input  i_req_valid, i_req_dest, i_release,
    output o_grant_ack, o_input_locked, o_route_select, o_output_busy
  );

  modport master (
    output i_req_valid, i_req_dest, i_release,
    input  o_grant_ack, o_input_locked, o_route_select, o_output_busy
  );
endinterface

// File: rtl/rr_switch_allocator.sv
// Per-output round-robin switch allocator: each output locks to one input from
// grant until that input's tail-flit release; all outputs are registered.
module rr_switch_allocator #(
  parameter int INPUTS        = 4,
  parameter int OUTPUTS       = 4,
  parameter int REQUEST_WIDTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_switch_allocator_if.slave bus
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                   r_state     [OUTPUTS];
  state_e                   w_state_nxt [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] r_owner     [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] w_owner_nxt [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] r_ptr       [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] w_ptr_nxt   [OUTPUTS];
  logic [REQUEST_WIDTH-1:0] w_winner    [OUTPUTS];
  logic                     w_found     [OUTPUTS];
  logic [INPUTS-1:0]        w_cand      [OUTPUTS];
  logic [INPUTS-1:0]        r_grant_ack;
  logic [INPUTS-1:0]        w_grant_nxt;
  logic [INPUTS-1:0]        r_input_locked;
  logic [INPUTS-1:0]        w_locked_nxt;

  // (base + k) modulo INPUTS without a divider; k never exceeds INPUTS-1.
  function automatic logic [REQUEST_WIDTH-1:0] wrap_add(input logic [REQUEST_WIDTH-1:0] base,
                                                        input int k);
    int sum;
    sum = int'(base) + k;
    if (sum >= INPUTS) begin
      sum = sum - INPUTS;
    end else begin
      sum = sum;
    end
    return REQUEST_WIDTH'(sum);
  endfunction

  // Out-of-range destinations match no output, so they are never granted.
  for (genvar o = 0; o < OUTPUTS; o++) begin : g_cand
    for (genvar i = 0; i < INPUTS; i++) begin : g_in
      assign w_cand[o][i] = bus.i_req_valid[i] && !r_input_locked[i] &&
                            (bus.i_req_dest[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
    end
  end

  // Rotating first-candidate search starting at each output's pointer.
  always_comb begin
    for (int o = 0; o < OUTPUTS; o++) begin
      w_found[o]  = 1'b0;
      w_winner[o] = '0;
      for (int k = 0; k < INPUTS; k++) begin
        if (!w_found[o] && w_cand[o][wrap_add(r_ptr[o], k)]) begin
          w_found[o]  = 1'b1;
          w_winner[o] = wrap_add(r_ptr[o], k);
        end else begin
          w_found[o]  = w_found[o];
        end
      end
    end
  end

  // Per-output IDLE/LOCKED next state, grant pulses and input lock updates.
  always_comb begin
    w_grant_nxt  = '0;
    w_locked_nxt = r_input_locked;
    for (int o = 0; o < OUTPUTS; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_ptr_nxt[o]   = r_ptr[o];
      case (r_state[o])
        ST_IDLE: begin
          if (w_found[o]) begin
            w_state_nxt[o]              = ST_LOCKED;
            w_owner_nxt[o]              = w_winner[o];
            w_ptr_nxt[o]                = wrap_add(w_winner[o], 1);
            w_grant_nxt[w_winner[o]]    = 1'b1;
            w_locked_nxt[w_winner[o]]   = 1'b1;
          end else begin
            w_state_nxt[o] = ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (bus.i_release[r_owner[o]]) begin
            w_state_nxt[o]            = ST_IDLE;
            w_owner_nxt[o]            = '0;
            w_locked_nxt[r_owner[o]]  = 1'b0;
          end else begin
            w_state_nxt[o] = ST_LOCKED;
          end
        end
        default: begin
          w_state_nxt[o] = ST_IDLE;
          w_owner_nxt[o] = '0;
        end
      endcase
    end
  end

  // State, owner, pointer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < OUTPUTS; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_ptr[o]   <= '0;
      end
      r_grant_ack    <= '0;
      r_input_locked <= '0;
    end else begin
      for (int o = 0; o < OUTPUTS; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_ptr[o]   <= w_ptr_nxt[o];
      end
      r_grant_ack    <= w_grant_nxt;
      r_input_locked <= w_locked_nxt;
    end
  end

  // Owner is cleared on release, so route_select reads 0 whenever idle.
  for (genvar o = 0; o < OUTPUTS; o++) begin : g_out
    assign bus.o_route_select[o*REQUEST_WIDTH +: REQUEST_WIDTH] = r_owner[o];
    assign bus.o_output_busy[o] = (r_state[o] == ST_LOCKED);
  end

  assign bus.o_grant_ack    = r_grant_ack;
  assign bus.o_input_locked = r_input_locked;

endmodule
